instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 123 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, one-outstanding imem req/ack, single instruction buffer to decode.
// Fetch latency is ack+1; decode backpressure holds the buffered instruction and suppresses new requests.
module instr_fetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            pcsrc,
  input  logic [XLEN-1:0] pc_target,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  output logic [31:0]     fetch_count
);

  typedef enum logic {S_REQ, S_HOLD} state_t;

  localparam logic [XLEN-1:0] FOUR       = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     count_q, count_d;
  logic            kill_q, kill_d;
  logic            req_en_q, req_en_d;
  logic            accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      pc_out_q <= RESET_PC;
      instr_q  <= NOP_INSTR;
      count_q  <= '0;
      kill_q   <= 1'b0;
      req_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      count_q  <= count_d;
      kill_q   <= kill_d;
      req_en_q <= req_en_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    count_d  = count_q;
    kill_d   = kill_q;
    req_en_d = 1'b1;
    accept   = (state_q == S_HOLD) && instr_ready;

    if (accept) begin
      count_d = count_q + 32'd1;
    end

    if (flush) begin
      pc_d    = flush_pc;
      instr_d = NOP_INSTR;
      state_d = S_REQ;
      // A request still in flight will be answered later; that answer belongs to the old pc.
      if (state_q == S_REQ) begin
        req_en_d = 1'b0;
        if (imem_ack) begin
          kill_d = 1'b0;
        end else if (imem_req) begin
          kill_d = 1'b1;
        end
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem_ack && kill_q) begin
            kill_d = 1'b0;
          end else if (imem_ack && imem_req) begin
            instr_d  = imem_rdata;
            pc_out_d = pc_q;
            state_d  = S_HOLD;
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            pc_d    = pcsrc ? (pc_target & ALIGN_MASK) : pc_plus4;
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  assign imem_req    = (state_q == S_REQ) && req_en_q;
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == S_HOLD);
  assign instr       = instr_q;
  assign op          = instr_q[6:0];
  assign funct3      = instr_q[14:12];
  assign funct7      = instr_q[31:25];
  assign pc_out      = pc_out_q;
  assign pc_plus4    = pc_out_q + FOUR;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic against a transaction-level model.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] CONST_WORD = 32'h0050_0093;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        pcsrc;
  logic [31:0] pc_target;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] fetch_count;

  instr_fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .op(op), .funct3(funct3), .funct7(funct7),
    .pc_out(pc_out), .pc_plus4(pc_plus4),
    .pcsrc(pcsrc), .pc_target(pc_target),
    .flush(flush), .flush_pc(flush_pc),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // model of what the fetch unit should present
  bit          m_valid, m_kill, m_reqen;
  logic [31:0] m_pc, m_pcout, m_instr, m_cnt;

  // stimulus knobs
  int          k_rdy = 0;      // 0 low, 1 high, 2 random
  bit          k_rand = 0;
  bit          k_pcsrc = 0;
  bit          k_flush = 0;
  bit          k_const = 1;
  logic [31:0] k_tgt = '0;
  logic [31:0] k_fpc = '0;
  int          k_delay = 2;    // negative: random per request

  bit mem_pend = 0;
  int mem_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ CONST_WORD;
  endfunction

  function automatic logic [31:0] data_at(input logic [31:0] a);
    return k_const ? CONST_WORD : mem_word(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_init();
    m_valid = 0; m_kill = 0; m_reqen = 0;
    m_pc = '0; m_pcout = '0; m_instr = NOP; m_cnt = '0;
  endtask

  task automatic model_update();
    bit req, acc;
    if (reset) begin
      model_init();
      return;
    end
    req = !m_valid && m_reqen;
    acc = m_valid && instr_ready;
    if (acc) m_cnt = m_cnt + 1;
    if (flush) begin
      if (!m_valid) begin
        if (imem_ack) m_kill = 0;
        else if (req) m_kill = 1;
        m_reqen = 0;
      end else begin
        m_reqen = 1;
      end
      m_pc = flush_pc; m_valid = 0; m_instr = NOP;
    end else if (!m_valid) begin
      m_reqen = 1;
      if (imem_ack) begin
        if (m_kill) m_kill = 0;
        else begin
          m_instr = data_at(m_pc); m_pcout = m_pc; m_valid = 1;
        end
      end
    end else if (acc) begin
      m_pc = pcsrc ? (pc_target & 32'hFFFF_FFFC) : m_pcout + 32'd4;
      m_valid = 0;
    end
  endtask

  task automatic drive();
    instr_ready = (k_rdy == 2) ? 1'($urandom_range(0, 1)) : (k_rdy != 0);
    if (k_rand) begin
      pcsrc     = 1'($urandom_range(0, 1));
      pc_target = $urandom;
      flush     = ($urandom_range(0, 15) == 0);
      flush_pc  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
    end else begin
      pcsrc = k_pcsrc; pc_target = k_tgt; flush = k_flush; flush_pc = k_fpc;
    end
    if (reset) begin
      mem_pend = 0; imem_ack = 0; imem_rdata = '0;
    end else begin
      if (imem_req && !mem_pend) begin
        mem_pend = 1;
        mem_cnt = (k_delay < 0) ? int'($urandom_range(0, 4)) : k_delay;
      end
      if (mem_pend && imem_req && mem_cnt == 0) begin
        imem_ack = 1; imem_rdata = data_at(imem_addr); mem_pend = 0;
      end else begin
        imem_ack = 0; imem_rdata = $urandom;
        if (mem_pend && mem_cnt > 0) mem_cnt--;
      end
    end
  endtask

  task automatic compare();
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("imem_req", 32'(imem_req), 32'(!m_valid && m_reqen));
    chk("imem_addr", imem_addr, m_pc);
    chk("instr", instr, m_instr);
    chk("op", 32'(op), 32'(m_instr[6:0]));
    chk("funct3", 32'(funct3), 32'(m_instr[14:12]));
    chk("funct7", 32'(funct7), 32'(m_instr[31:25]));
    chk("pc_out", pc_out, m_pcout);
    chk("pc_plus4", pc_plus4, m_pcout + 32'd4);
    chk("fetch_count", fetch_count, m_cnt);
  endtask

  task automatic step();
    drive();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!instr_valid && n < 60) begin
      step();
      n++;
    end
    chk(nm, 32'(instr_valid), 32'd1);
  endtask

  task automatic async_reset_check(input string nm);
    #2 reset = 1'b1;
    #1;
    chk({nm, "_valid"}, 32'(instr_valid), 32'd0);
    chk({nm, "_req"}, 32'(imem_req), 32'd0);
    chk({nm, "_addr"}, imem_addr, 32'd0);
    chk({nm, "_instr"}, instr, NOP);
    chk({nm, "_pc_out"}, pc_out, 32'd0);
    chk({nm, "_count"}, fetch_count, 32'd0);
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; imem_ack = 0; imem_rdata = '0; instr_ready = 0;
    pcsrc = 0; pc_target = '0; flush = 0; flush_pc = '0;
    model_init();
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_count", fetch_count, 32'd0);
    step();
    step();
    reset = 1'b0;

    // sequential fetch of a constant word
    wait_valid("A_wait");
    chk("A_instr", instr, CONST_WORD);
    chk("A_op", 32'(op), 32'h13);
    chk("A_funct3", 32'(funct3), 32'd0);
    chk("A_funct7", 32'(funct7), 32'd0);
    chk("A_pc_out", pc_out, 32'd0);
    k_rdy = 1;
    for (int n = 0; n < 60 && fetch_count != 32'd3; n++) step();
    chk("A_count", fetch_count, 32'd3);
    chk("A_next_addr", imem_addr, 32'hC);

    // backpressure in HOLD
    k_const = 0; k_rdy = 0;
    wait_valid("B_wait");
    chk("B_pc_out", pc_out, 32'hC);
    for (int n = 0; n < 5; n++) begin
      step();
      chk("B_req_low", 32'(imem_req), 32'd0);
    end
    k_rdy = 1;
    step();
    chk("B_next_addr", imem_addr, 32'h10);
    chk("B_count", fetch_count, 32'd4);
    k_rdy = 0;

    // taken branch, pcsrc ignored without ready
    wait_valid("C_wait");
    chk("C_pc_out", pc_out, 32'h10);
    k_pcsrc = 1; k_tgt = 32'h43;
    step();
    step();
    chk("C_still_valid", 32'(instr_valid), 32'd1);
    k_rdy = 1;
    step();
    chk("C_branch_addr", imem_addr, 32'h40);
    chk("C_count", fetch_count, 32'd5);
    k_rdy = 0; k_pcsrc = 0; k_delay = 6;

    // flush with a request outstanding
    step();
    k_flush = 1; k_fpc = 32'h100;
    step();
    k_flush = 0;
    chk("D_req_drop", 32'(imem_req), 32'd0);
    chk("D_addr", imem_addr, 32'h100);
    wait_valid("D_wait");
    chk("D_pc_out", pc_out, 32'h100);
    chk("D_instr", instr, mem_word(32'h100));

    // flush coinciding with accept + taken branch
    k_delay = 1;
    k_rdy = 1; k_pcsrc = 1; k_tgt = 32'h80; k_flush = 1; k_fpc = 32'h200;
    step();
    k_rdy = 0; k_pcsrc = 0; k_flush = 0;
    chk("E_addr", imem_addr, 32'h200);
    chk("E_count", fetch_count, 32'd6);
    chk("E_instr", instr, NOP);
    chk("E_valid", 32'(instr_valid), 32'd0);
    chk("E_req", 32'(imem_req), 32'd1);

    // asynchronous reset in REQ and in HOLD
    async_reset_check("F_req");
    wait_valid("F_wait");
    async_reset_check("F_hold");

    // pc wraparound
    k_flush = 1; k_fpc = 32'hFFFF_FFFC;
    step();
    k_flush = 0;
    wait_valid("G_wait");
    chk("G_pc_out", pc_out, 32'hFFFF_FFFC);
    chk("G_pc_plus4", pc_plus4, 32'd0);
    k_rdy = 1;
    step();
    chk("G_wrap_addr", imem_addr, 32'd0);

    // random traffic
    k_rand = 1; k_rdy = 2; k_delay = -1;
    for (int n = 0; n < 3000; n++) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
